// File: rtl/sdrc_wb_traffic_gen.sv
// sdrc_wb_traffic_gen: Wishbone burst master that writes address-derived data in
// bursts, reads it back, and counts miscompares; drives sdrc_top's wb_* port.
// Optional macro TGEN_ERR_LOG_EN adds first-miscompare capture ports
// (err_addr, err_exp, err_act).
module sdrc_wb_traffic_gen #(
    parameter int unsigned APP_AW       = 26,
    parameter int unsigned WB_DW        = 32,
    parameter int unsigned BURST_MAX    = 16,
    parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0000,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start,
    input  logic                 sdr_init_done,
    input  logic [APP_AW-1:0]    cfg_start_addr,
    input  logic [7:0]           cfg_burst_len,
    input  logic [15:0]          cfg_num_xfr,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [APP_AW-1:0]    wb_addr_o,
    output logic [WB_DW-1:0]     wb_dat_o,
    output logic [WB_DW/8-1:0]   wb_sel_o,
    output logic [2:0]           wb_cti_o,
    input  logic                 wb_ack_i,
    input  logic [WB_DW-1:0]     wb_dat_i,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          err_cnt,
    output logic [15:0]          xfr_cnt,
    output logic                 timeout
`ifdef TGEN_ERR_LOG_EN
    ,
    output logic [APP_AW-1:0]    err_addr,
    output logic [WB_DW-1:0]     err_exp,
    output logic [WB_DW-1:0]     err_act
`endif
);

    localparam int unsigned    BYTES   = WB_DW / 8;
    localparam int unsigned    TW      = $clog2(TIMEOUT + 1);
    localparam logic [WB_DW-1:0] SEED_W = {(WB_DW / 32){PATTERN_SEED}};
    localparam logic [2:0]     CTI_INC = 3'b010;
    localparam logic [2:0]     CTI_END = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_INIT, S_WR, S_GAP_W, S_RD, S_GAP_R, S_DONE
    } state_t;

    // Expected data for a beat address; shared by write generation and read check.
    function automatic logic [WB_DW-1:0] pattern(input logic [APP_AW-1:0] a);
        return SEED_W ^ WB_DW'(a);
    endfunction

    state_t            state;
    logic [APP_AW-1:0] base;
    logic [7:0]        bl;
    logic [7:0]        beat;
    logic [15:0]       num;
    logic [TW-1:0]     tmo_cnt;
`ifdef TGEN_ERR_LOG_EN
    logic              err_logged;
`endif

    logic [7:0]        bl_c;
    logic [7:0]        next_beat_c;
    logic              last_c;
    logic              next_last_c;
    logic [2:0]        first_cti_c;
    logic [APP_AW-1:0] next_addr_c;
    logic [APP_AW-1:0] next_base_c;
    logic              mismatch_c;
    logic              tmo_hit_c;
    logic [15:0]       xfr_inc_c;

    // Burst-length clamp, beat/address stepping and compare helpers.
    always_comb begin
        bl_c = cfg_burst_len;
        if (cfg_burst_len == 8'd0) begin
            bl_c = 8'd1;
        end else if (32'(cfg_burst_len) > BURST_MAX) begin
            bl_c = 8'(BURST_MAX);
        end
        next_beat_c = beat + 8'd1;
        last_c      = (next_beat_c == bl);
        next_last_c = ((next_beat_c + 8'd1) == bl);
        first_cti_c = (bl == 8'd1) ? CTI_END : CTI_INC;
        next_addr_c = wb_addr_o + APP_AW'(BYTES);
        next_base_c = base + APP_AW'(32'(bl) * BYTES);
        mismatch_c  = (wb_dat_i != pattern(wb_addr_o));
        tmo_hit_c   = (tmo_cnt == TW'(TIMEOUT - 1));
        xfr_inc_c   = xfr_cnt + 16'd1;
    end

    // Run sequencer with registered Wishbone and status outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            base      <= '0;
            bl        <= 8'd0;
            beat      <= 8'd0;
            num       <= 16'd0;
            tmo_cnt   <= '0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            wb_cti_o  <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_cnt   <= 16'd0;
            xfr_cnt   <= 16'd0;
            timeout   <= 1'b0;
`ifdef TGEN_ERR_LOG_EN
            err_logged <= 1'b0;
            err_addr   <= '0;
            err_exp    <= '0;
            err_act    <= '0;
`endif
        end else begin
            wb_sel_o <= '1;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        base    <= cfg_start_addr;
                        bl      <= bl_c;
                        num     <= cfg_num_xfr;
                        err_cnt <= 16'd0;
                        xfr_cnt <= 16'd0;
                        done    <= 1'b0;
                        timeout <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_WAIT_INIT;
`ifdef TGEN_ERR_LOG_EN
                        err_logged <= 1'b0;
                        err_addr   <= '0;
                        err_exp    <= '0;
                        err_act    <= '0;
`endif
                    end
                end
                S_WAIT_INIT: begin
                    if (sdr_init_done) begin
                        if (num == 16'd0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            wb_cyc_o  <= 1'b1;
                            wb_stb_o  <= 1'b1;
                            wb_we_o   <= 1'b1;
                            wb_addr_o <= base;
                            wb_dat_o  <= pattern(base);
                            wb_cti_o  <= first_cti_c;
                            beat      <= 8'd0;
                            tmo_cnt   <= '0;
                            state     <= S_WR;
                        end
                    end
                end
                S_WR, S_RD: begin
                    if (wb_ack_i) begin
                        tmo_cnt <= '0;
                        if (state == S_RD && mismatch_c) begin
                            if (err_cnt != 16'hFFFF) begin
                                err_cnt <= err_cnt + 16'd1;
                            end
`ifdef TGEN_ERR_LOG_EN
                            if (!err_logged) begin
                                err_logged <= 1'b1;
                                err_addr   <= wb_addr_o;
                                err_exp    <= pattern(wb_addr_o);
                                err_act    <= wb_dat_i;
                            end
`endif
                        end
                        if (last_c) begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            wb_we_o  <= 1'b0;
                            wb_cti_o <= 3'b000;
                            state    <= (state == S_WR) ? S_GAP_W : S_GAP_R;
                        end else begin
                            beat      <= next_beat_c;
                            wb_addr_o <= next_addr_c;
                            wb_dat_o  <= pattern(next_addr_c);
                            wb_cti_o  <= next_last_c ? CTI_END : CTI_INC;
                        end
                    end else if (tmo_hit_c) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_cti_o <= 3'b000;
                        timeout  <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_GAP_W: begin
                    wb_cyc_o  <= 1'b1;
                    wb_stb_o  <= 1'b1;
                    wb_we_o   <= 1'b0;
                    wb_addr_o <= base;
                    wb_dat_o  <= pattern(base);
                    wb_cti_o  <= first_cti_c;
                    beat      <= 8'd0;
                    tmo_cnt   <= '0;
                    state     <= S_RD;
                end
                S_GAP_R: begin
                    xfr_cnt <= xfr_inc_c;
                    base    <= next_base_c;
                    if (xfr_inc_c == num) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        wb_we_o   <= 1'b1;
                        wb_addr_o <= next_base_c;
                        wb_dat_o  <= pattern(next_base_c);
                        wb_cti_o  <= first_cti_c;
                        beat      <= 8'd0;
                        tmo_cnt   <= '0;
                        state     <= S_WR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sdrc_wb_traffic_gen.md
Name: sdrc_wb_traffic_gen

Overview:
Parametrised, synthesizable Wishbone burst master that replaces the fixed-width procedural stimulus used on the SDRAM controller's Wishbone port. After SDRAM init completes it runs N write-burst/read-burst pairs with an address-derived data pattern, compares read data on the fly, and reports pass/fail counts. It drives sdrc_top's wb_* inputs directly, for both simulation and on-board self-test. It scales across SDRAM widths and burst lengths.

Parameters:
APP_AW, 26, Wishbone byte-address width.
WB_DW, 32, Wishbone data width (32/64); byte lanes = WB_DW/8.
BURST_MAX, 16, maximum beats per burst; cfg_burst_len is clamped to this value.
PATTERN_SEED, 32'hA5A5_0000, XOR seed for the data pattern (replicated to WB_DW).
TIMEOUT, 1024, cycles without wb_ack_i before a beat is aborted.

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset; asynchronous, active-high
start  in  1  one-cycle pulse; starts a run when idle
sdr_init_done  in  1  SDRAM init complete
cfg_start_addr  in  APP_AW  base byte address; sampled on start
cfg_burst_len  in  8  beats per burst; sampled on start
cfg_num_xfr  in  16  write/read pair count; sampled on start
wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone cycle, strobe, write enable
wb_addr_o  out  APP_AW  beat byte address
wb_dat_o  out  WB_DW  write data
wb_sel_o  out  WB_DW/8  byte selects; always all ones
wb_cti_o  out  3  cycle type
wb_ack_i  in  1  acknowledge
wb_dat_i  in  WB_DW  read data
busy  out  1  run in progress
done  out  1  run finished; sticky until next start
err_cnt  out  16  miscompared beats; saturates at FFFF
xfr_cnt  out  16  completed pairs
timeout  out  1  run aborted on timeout; sticky until next start

Behaviour:
- Reset: all outputs 0; FSM in IDLE.
- FSM states: IDLE, WAIT_INIT, WR, GAP_W, RD, GAP_R, DONE.
  - IDLE + start: latch cfg_*, clear err_cnt, xfr_cnt, done, timeout; set busy; go to WAIT_INIT. start is ignored in any state other than IDLE or DONE.
  - WAIT_INIT: go to WR on the first cycle sdr_init_done = 1.
  - WR: cyc = stb = we = 1 for BL beats; on wb_ack_i, advance the beat and address.
  - GAP_W: exactly 1 cycle with cyc = stb = 0, then go to RD at the same base address.
  - RD: cyc = stb = 1, we = 0; on each wb_ack_i, compare wb_dat_i against the expected pattern.
  - GAP_R: increment xfr_cnt; advance base by BL*(WB_DW/8); if xfr_cnt == num_xfr go to DONE, else go to WR.
  - DONE: busy = 0, done = 1. start restarts the run as from IDLE.
- Burst length: BL = cfg_burst_len, with 0 treated as 1 and values above BURST_MAX clamped to BURST_MAX.
- cfg_num_xfr = 0: WAIT_INIT goes straight to DONE; no bus cycles.
- Cycle type: wb_cti_o = 3'b010 on every beat except the last, which is 3'b111. For BL = 1 the only beat is 3'b111.
- Beat address: base + beat*(WB_DW/8), truncated to APP_AW bits, so addresses wrap at 2^APP_AW.
- Data pattern: data(addr) = PATTERN_SEED ^ zero-extended addr. Writes and read-compare use the same function.
- Ack timing: wb_ack_i may arrive any number of cycles after stb. Outputs hold stable until ack. The next beat's address and data appear the cycle after ack (one beat per ack, zero added wait). A wb_ack_i seen while stb = 0 is ignored.
- Error counting: err_cnt increments on each read beat with a mismatch, at most once per beat.
- Timeout: a per-beat counter reloads on each ack or new beat. On reaching TIMEOUT: drop cyc/stb, set timeout = 1 and done = 1, go to DONE. xfr_cnt keeps its partial value.
- Reset mid-run: immediately drops cyc/stb and returns to IDLE, with no bus completion.
- sdr_init_done falling mid-run is not monitored.

Optional Feature:
TGEN_ERR_LOG_EN.
- Defined: adds outputs err_addr[APP_AW-1:0], err_exp[WB_DW-1:0], err_act[WB_DW-1:0]. They capture the first miscompare of a run, are cleared on start, and are frozen after capture.
- Undefined: these ports and registers do not exist; all other behaviour is unchanged.

Test Plan:
- Basic run: start with addr 0x0000100, BL = 4, num = 2, ideal memory model with 1-cycle ack. Required: beats at addresses 0x100/104/108/10C written with data 0xA5A5_0100.., cti 010,010,010,111, then read back; next pair starts at 0x110. Final xfr_cnt = 2, err_cnt = 0, done = 1.
- Single beat: BL = 0. Required: treated as one beat with cti = 111. BL = 40 with BURST_MAX = 16 → exactly 16 beats per burst.
- Error injection: memory model corrupts bit 0 of the read at 0x108. Required: err_cnt = 1. With TGEN_ERR_LOG_EN defined: err_addr = 0x108, err_exp = 0xA5A5_0108, err_act = 0xA5A5_0109.
- Wait states and wrap: random ack delay of 0–20 cycles, base 0x3FFFFF8 with BL = 4. Required: addresses go 0x3FFFFF8, 0x3FFFFFC, 0x0000000, 0x0000004; data stable across waits; err_cnt = 0.
- Timeout: memory model never acks. Required: after 1024 cycles cyc = 0, timeout = 1, done = 1, busy = 0.
- Reset mid-burst: assert wb_rst_i during the second write beat. Required: all outputs 0 in the same cycle (asynchronous reset). A new start after release runs cleanly from the start address.
